alu_cmp_32: RTL and testbench

Registered 32-bit four-function ALU with NZCV flag generation and a full set of unsigned and signed condition decodes derived from those flags. It sits in the datapath wherever a compare-and-branch or ALU-with-flags result is needed. Internally it is three parts:
- an `alu_4f_32`-style ALU core;
- an unsigned condition decoder;
- a signed condition decoder.

All outputs are captured in one output register stage.

---
 rtl/alu_cmp_32_if.sv | 32 +++
 rtl/alu_cmp_32.sv | 105 ++++++++++
 tb/tb_alu_cmp_32.sv | 114 +++++++++++
 3 files changed

// File: rtl/alu_cmp_32_if.sv
// rtl/alu_cmp_32_if.sv - operand/result bundle for alu_cmp_32
//
// Purpose: groups the request side (in_valid, a, b, control) and the
// registered response side (out_valid, result, NZCV flags, unsigned and
// signed condition decodes) of alu_cmp_32.
// Modports:
//   master - drives in_valid/a/b/control, observes everything else
//   slave  - the ALU: consumes the request, drives the response
interface alu_cmp_32_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       control;

    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             n, z, c, v;
    logic             hs, ls, hi, lo;
    logic             ge, le, gt, lt;

    modport master (
        output in_valid, a, b, control,
        input  out_valid, result, n, z, c, v, hs, ls, hi, lo, ge, le, gt, lt
    );

    modport slave (
        input  in_valid, a, b, control,
        output out_valid, result, n, z, c, v, hs, ls, hi, lo, ge, le, gt, lt
    );
endinterface

// File: rtl/alu_cmp_32.sv
// rtl/alu_cmp_32.sv - registered 4-function ALU with NZCV flags and condition decodes
//
// Purpose: computes ADD/SUB/AND/OR of a and b, derives NZCV, and decodes the
// unsigned (hs/ls/hi/lo) and signed (ge/le/gt/lt) conditions from those flags.
// Everything is combinational up to a single output register (1-cycle latency,
// full throughput, no backpressure).
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; clears every registered output
//   bus   - alu_cmp_32_if.slave: in_valid/a/b/control in;
//           out_valid/result/n/z/c/v/hs/ls/hi/lo/ge/le/gt/lt out
// control: 00 ADD, 01 SUB (a - b), 10 AND, 11 OR
module alu_cmp_32 #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    alu_cmp_32_if.slave   bus
);

    // ALU core
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] res_d;
    logic             n_d, z_d, c_d, v_d;

    // SUB reuses the adder as a + ~b + 1; control[0] is both the invert
    // select and the carry-in.
    assign b_op    = bus.control[0] ? ~bus.b : bus.b;
    assign sum_ext = {1'b0, bus.a} + {1'b0, b_op} + {{WIDTH{1'b0}}, bus.control[0]};
    assign sum     = sum_ext[WIDTH-1:0];

    always_comb begin
        res_d = sum;
        case (bus.control)
            2'b10:   res_d = bus.a & bus.b;
            2'b11:   res_d = bus.a | bus.b;
            default: res_d = sum;
        endcase
    end

    assign n_d = res_d[WIDTH-1];
    assign z_d = (res_d == '0);
    // Logic ops never report carry or overflow.
    assign c_d = sum_ext[WIDTH] & ~bus.control[1];
    assign v_d = ~(bus.a[WIDTH-1] ^ bus.b[WIDTH-1] ^ bus.control[0])
               & (bus.a[WIDTH-1] ^ sum[WIDTH-1])
               & ~bus.control[1];

    // Unsigned decoder
    logic hs_d, ls_d, hi_d, lo_d;
    assign hs_d = c_d;
    assign lo_d = ~c_d;
    assign hi_d = c_d & ~z_d;
    assign ls_d = ~c_d | z_d;

    // Signed decoder
    logic nv;
    logic ge_d, le_d, gt_d, lt_d;
    assign nv   = n_d ^ v_d;
    assign ge_d = ~nv;
    assign lt_d = nv;
    assign gt_d = ~z_d & ~nv;
    assign le_d = z_d | nv;

    // Output register: payload only updates on a valid edge, out_valid
    // follows in_valid every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.n         <= 1'b0;
            bus.z         <= 1'b0;
            bus.c         <= 1'b0;
            bus.v         <= 1'b0;
            bus.hs        <= 1'b0;
            bus.ls        <= 1'b0;
            bus.hi        <= 1'b0;
            bus.lo        <= 1'b0;
            bus.ge        <= 1'b0;
            bus.le        <= 1'b0;
            bus.gt        <= 1'b0;
            bus.lt        <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.result <= res_d;
                bus.n      <= n_d;
                bus.z      <= z_d;
                bus.c      <= c_d;
                bus.v      <= v_d;
                bus.hs     <= hs_d;
                bus.ls     <= ls_d;
                bus.hi     <= hi_d;
                bus.lo     <= lo_d;
                bus.ge     <= ge_d;
                bus.le     <= le_d;
                bus.gt     <= gt_d;
                bus.lt     <= lt_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmp_32.sv
// tb/tb_alu_cmp_32.sv - directed self-checking bench for alu_cmp_32
module tb_alu_cmp_32;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    alu_cmp_32_if #(.WIDTH(32)) bus ();

    alu_cmp_32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // {n,z,c,v, hs,ls,hi,lo, ge,le,gt,lt}
    function automatic logic [11:0] flags();
        return {bus.n, bus.z, bus.c, bus.v,
                bus.hs, bus.ls, bus.hi, bus.lo,
                bus.ge, bus.le, bus.gt, bus.lt};
    endfunction

    // Present one valid op, let one edge capture it, then check just after the edge.
    task automatic op(input string tag, input logic [1:0] ctl, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_res,
                      input logic [11:0] exp_flags);
        bus.in_valid = 1'b1;
        bus.control  = ctl;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
        check({tag, ".valid"},  {31'd0, bus.out_valid}, 32'd1);
        check({tag, ".result"}, bus.result, exp_res);
        check({tag, ".flags"},  {20'd0, flags()}, {20'd0, exp_flags});
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.control  = 2'b00;
        bus.a        = 32'd0;
        bus.b        = 32'd0;

        #3;
        check("rst.valid",  {31'd0, bus.out_valid}, 32'd0);
        check("rst.result", bus.result, 32'd0);
        check("rst.flags",  {20'd0, flags()}, 32'd0);

        @(negedge clk);
        reset = 1'b0;

        // Back-to-back stream: a new op every cycle, each checked one edge later.
        op("sub_255_25",  OP_SUB, 32'd255,        32'd25,         32'd230,        12'b0010_1010_1010);
        op("sub_457_498", OP_SUB, 32'd457,        32'd498,        32'hFFFF_FFD7,  12'b1000_0101_0101);
        op("sub_0_0",     OP_SUB, 32'd0,          32'd0,          32'd0,          12'b0110_1100_1100);
        op("sub_min_max", OP_SUB, 32'h8000_0000,  32'h7FFF_FFFF,  32'h0000_0001,  12'b0011_1010_0101);
        op("sub_neg_neg", OP_SUB, 32'h8000_ABCD,  32'h8FFF_FFFF,  32'hF000_ABCE,  12'b1000_0101_0101);
        op("sub_big",     OP_SUB, 32'd752456,     32'd498,        32'd751958,     12'b0010_1010_1010);
        op("add_wrap",    OP_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          12'b0110_1100_1100);
        op("add_ovf",     OP_ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  12'b1001_0101_1010);
        op("and_mask",    OP_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  12'b1000_0101_0101);
        op("or_zero",     OP_OR,  32'd0,          32'd0,          32'd0,          12'b0100_0101_1100);
        op("or_mix",      OP_OR,  32'h1234_0000,  32'h0000_5678,  32'h1234_5678,  12'b0000_0101_1010);

        // in_valid low: out_valid drops, payload holds from or_mix.
        bus.in_valid = 1'b0;
        bus.control  = OP_AND;
        bus.a        = 32'hDEAD_BEEF;
        bus.b        = 32'd0;
        @(posedge clk);
        #1;
        check("hold.valid",  {31'd0, bus.out_valid}, 32'd0);
        check("hold.result", bus.result, 32'h1234_5678);
        check("hold.flags",  {20'd0, flags()}, {20'd0, 12'b0000_0101_1010});

        // Capture a value, then reset mid-cycle: outputs clear with no clock edge.
        op("pre_rst", OP_SUB, 32'd457, 32'd498, 32'hFFFF_FFD7, 12'b1000_0101_0101);
        #1;
        reset = 1'b1;
        #1;
        check("midrst.valid",  {31'd0, bus.out_valid}, 32'd0);
        check("midrst.result", bus.result, 32'd0);
        check("midrst.flags",  {20'd0, flags()}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // First edge after reset release captures normally.
        op("post_rst", OP_SUB, 32'd255, 32'd25, 32'd230, 12'b0010_1010_1010);

        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
